// File: rtl/sauria_demo_pkg.sv
// Shared register map, ID constant and controller state encoding for the
// SAURIA demo control/status register block.
package sauria_demo_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = 3;

  localparam logic [7:0] OFF_CTRL          = 8'h00;
  localparam logic [7:0] OFF_STATUS        = 8'h04;
  localparam logic [7:0] OFF_CYCLES        = 8'h08;
  localparam logic [7:0] OFF_TIMEOUT_LIMIT = 8'h0C;
  localparam logic [7:0] OFF_ID            = 8'h10;

  // Word indices as seen on address bits [4:2]
  localparam logic [IdxWidth-1:0] IDX_CTRL   = IdxWidth'(OFF_CTRL >> 2);
  localparam logic [IdxWidth-1:0] IDX_STATUS = IdxWidth'(OFF_STATUS >> 2);
  localparam logic [IdxWidth-1:0] IDX_CYCLES = IdxWidth'(OFF_CYCLES >> 2);
  localparam logic [IdxWidth-1:0] IDX_LIMIT  = IdxWidth'(OFF_TIMEOUT_LIMIT >> 2);
  localparam logic [IdxWidth-1:0] IDX_ID     = IdxWidth'(OFF_ID >> 2);

  localparam logic [DataWidth-1:0] SAURIA_ID = 32'h5A52_1A00;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sauria_ctrl_state_e;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLEAR  = 2;

  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_DONE    = 1;
  localparam int unsigned STATUS_TIMEOUT = 2;

endpackage

// File: rtl/sauria_demo_ctrl_regs.sv
// Regbus-mapped control/status block for one SAURIA job: start/abort pulses,
// cycle counter with optional timeout, sticky flags and a level interrupt.
module sauria_demo_ctrl_regs
  import sauria_demo_pkg::*;
#(
  parameter int unsigned          AddrWidth      = 32,
  parameter logic [DataWidth-1:0] TimeoutDefault = 32'd0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [DataWidth-1:0] reg_wdata_i,
  input  logic [StrbWidth-1:0] reg_wstrb_i,
  output logic                 reg_ready_o,
  output logic [DataWidth-1:0] reg_rdata_o,
  output logic                 reg_error_o,
  output logic                 sauria_start_o,
  output logic                 sauria_abort_o,
  input  logic                 sauria_done_i,
  output logic                 irq_o
);

  sauria_ctrl_state_e   state_q, state_d;
  logic [DataWidth-1:0] cycles_q, cycles_d;
  logic [DataWidth-1:0] limit_q, limit_d;
  logic                 irq_en_q, irq_en_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 start_q, start_d;
  logic                 abort_q, abort_d;
  logic                 irq_q, irq_d;

  logic [IdxWidth-1:0]  idx;
  logic                 mapped;
  logic                 read_only;
  logic                 access_err;
  logic                 wr_ok;
  logic                 ctrl_wr;
  logic                 status_wr;
  logic                 limit_wr;
  logic                 start_req;
  logic                 clear_req;
  logic                 timeout_hit;
  logic                 unused_addr;

  assign idx         = reg_addr_i[4:2];
  assign unused_addr = ^{reg_addr_i[AddrWidth-1:5], reg_addr_i[1:0]};

  // Address decode: unmapped words and writes to RO words are errors
  always_comb begin
    mapped    = 1'b1;
    read_only = 1'b0;
    case (idx)
      IDX_CTRL, IDX_STATUS, IDX_LIMIT: read_only = 1'b0;
      IDX_CYCLES, IDX_ID:              read_only = 1'b1;
      default:                         mapped    = 1'b0;
    endcase
  end

  assign access_err  = reg_valid_i & (~mapped | (reg_write_i & read_only));
  assign wr_ok       = reg_valid_i & reg_write_i & ~access_err;
  assign ctrl_wr     = wr_ok & (idx == IDX_CTRL) & reg_wstrb_i[0];
  assign status_wr   = wr_ok & (idx == IDX_STATUS) & reg_wstrb_i[0];
  assign limit_wr    = wr_ok & (idx == IDX_LIMIT);
  assign start_req   = ctrl_wr & reg_wdata_i[CTRL_START];
  assign clear_req   = ctrl_wr & reg_wdata_i[CTRL_CLEAR];
  assign timeout_hit = (limit_q != '0) && (cycles_q == limit_q - DataWidth'(1));

  assign reg_ready_o = reg_valid_i;
  assign reg_error_o = access_err;

  // Read mux returns pre-edge register values
  always_comb begin
    reg_rdata_o = '0;
    if (reg_valid_i && !reg_write_i && !access_err) begin
      case (idx)
        IDX_CTRL:   reg_rdata_o[CTRL_IRQ_EN] = irq_en_q;
        IDX_STATUS: begin
          reg_rdata_o[STATUS_BUSY]    = (state_q == RUN);
          reg_rdata_o[STATUS_DONE]    = done_q;
          reg_rdata_o[STATUS_TIMEOUT] = tmo_q;
        end
        IDX_CYCLES: reg_rdata_o = cycles_q;
        IDX_LIMIT:  reg_rdata_o = limit_q;
        IDX_ID:     reg_rdata_o = SAURIA_ID;
        default:    reg_rdata_o = '0;
      endcase
    end
  end

  // Next-state: register writes first, then FSM events so flag sets win
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    limit_d  = limit_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;

    if (ctrl_wr) irq_en_d = reg_wdata_i[CTRL_IRQ_EN];
    if (status_wr && reg_wdata_i[STATUS_DONE])    done_d = 1'b0;
    if (status_wr && reg_wdata_i[STATUS_TIMEOUT]) tmo_d  = 1'b0;
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      if (limit_wr && reg_wstrb_i[b]) limit_d[8*b +: 8] = reg_wdata_i[8*b +: 8];
    end

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d  = RUN;
          cycles_d = '0;
          start_d  = 1'b1;
        end
      end
      RUN: begin
        if (sauria_done_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          cycles_d = limit_q;
          tmo_d    = 1'b1;
          abort_d  = 1'b1;
        end else if (clear_req) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + DataWidth'(1);
        end
      end
    endcase

    irq_d = irq_en_d & (done_d | tmo_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cycles_q <= '0;
      limit_q  <= TimeoutDefault;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      limit_q  <= limit_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      irq_q    <= irq_d;
    end
  end

  assign sauria_start_o = start_q;
  assign sauria_abort_o = abort_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_sauria_demo_ctrl_regs.sv
// Directed plus randomized bench for sauria_demo_ctrl_regs with an
// event-ordering reference model for job outcomes.
module tb_sauria_demo_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_valid;
  logic        reg_write;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic        start_o;
  logic        abort_o;
  logic        done_i;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  logic [31:0] op_rdata;

  always #5 clk = ~clk;

  sauria_demo_ctrl_regs #(.AddrWidth(32), .TimeoutDefault(32'd7)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_wstrb_i(reg_wstrb),
    .reg_ready_o(reg_ready), .reg_rdata_o(reg_rdata), .reg_error_o(reg_error),
    .sauria_start_o(start_o), .sauria_abort_o(abort_o),
    .sauria_done_i(done_i), .irq_o(irq)
  );

  always @(posedge clk) begin
    if (start_o === 1'b1) start_cnt++;
    if (abort_o === 1'b1) abort_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output logic er);
    @(negedge clk);
    reg_valid = 1'b1; reg_write = w; reg_addr = a; reg_wdata = wd; reg_wstrb = ws;
    #1;
    rd = reg_rdata;
    er = reg_error;
    @(posedge clk);
    #1;
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd; logic er;
    access(1'b1, a, wd, 4'hF, rd, er);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    access(1'b0, a, 32'h0, 4'h0, rd, er);
    check(tag, rd, exp);
  endtask

  // Edge k (k>=1) follows the START edge; done is sampled at edge d+1,
  // the side access (read or write of address ca) happens at edge c.
  task automatic run_job(input int d, input int c, input logic cw,
                         input logic [31:0] ca, input logic [31:0] cd);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      done_i = (d != 0 && k == d + 1);
      if (k == c) begin
        reg_valid = 1'b1; reg_write = cw; reg_addr = ca; reg_wdata = cd; reg_wstrb = 4'hF;
      end
      #1;
      if (k == c) op_rdata = reg_rdata;
      @(posedge clk);
      #1;
      done_i = 1'b0; reg_valid = 1'b0; reg_write = 1'b0;
    end
  endtask

  // Outcome of a job from the edge at which each event first fires
  task automatic predict(input int d, input int lim, input int c, output int cyc,
                         output int st, output int ab);
    int ed, et, ec;
    ed = (d != 0) ? d + 1 : 1000;
    et = (lim != 0) ? lim : 1000;
    ec = (c != 0) ? c : 1000;
    if (ed <= et && ed <= ec) begin cyc = d;     st = 2; ab = 0; end
    else if (et <= ec)        begin cyc = lim;   st = 4; ab = 1; end
    else                      begin cyc = c - 1; st = 0; ab = 1; end
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int s0, a0;
    int d, lim, c, ien, ecyc, est, eab;

    rst = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0;
    reg_wdata = '0; reg_wstrb = '0; done_i = 1'b0; op_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_irq", 32'(irq), 0);
    check("rst_start", 32'(start_o), 0);
    check("rst_abort", 32'(abort_o), 0);
    rd_chk("rst_ctrl", 32'h00, 32'h0);
    rd_chk("rst_status", 32'h04, 32'h0);
    rd_chk("rst_cycles", 32'h08, 32'h0);
    rd_chk("rst_limit", 32'h0C, 32'd7);
    rd_chk("rst_id", 32'h10, 32'h5A52_1A00);

    // Normal completion
    wr(32'h0C, 32'h0);
    s0 = start_cnt; a0 = abort_cnt;
    wr(32'h00, 32'h1);
    run_job(10, 5, 1'b0, 32'h04, 32'h0);
    check("busy_mid", op_rdata, 32'h1);
    rd_chk("done_cycles", 32'h08, 32'd10);
    rd_chk("done_status", 32'h04, 32'h2);
    check("done_irq_off", 32'(irq), 0);
    check("done_starts", 32'(start_cnt - s0), 1);
    check("done_aborts", 32'(abort_cnt - a0), 0);
    wr(32'h00, 32'h2);
    check("irq_rise", 32'(irq), 1);
    rd_chk("ctrl_rb", 32'h00, 32'h2);

    // Timeout
    wr(32'h04, 32'h6);
    check("irq_w1c", 32'(irq), 0);
    wr(32'h0C, 32'd5);
    s0 = start_cnt; a0 = abort_cnt;
    wr(32'h00, 32'h3);
    run_job(0, 0, 1'b0, 32'h0, 32'h0);
    rd_chk("to_cycles", 32'h08, 32'd5);
    rd_chk("to_status", 32'h04, 32'h4);
    check("to_aborts", 32'(abort_cnt - a0), 1);
    check("to_starts", 32'(start_cnt - s0), 1);
    check("to_irq", 32'(irq), 1);

    // CLEAR three edges into the run
    wr(32'h04, 32'h6);
    wr(32'h0C, 32'h0);
    a0 = abort_cnt;
    wr(32'h00, 32'h3);
    run_job(0, 3, 1'b1, 32'h00, 32'h6);
    rd_chk("clr_cycles", 32'h08, 32'd2);
    rd_chk("clr_status", 32'h04, 32'h0);
    check("clr_aborts", 32'(abort_cnt - a0), 1);

    // Done on the timeout edge
    wr(32'h0C, 32'd5);
    a0 = abort_cnt;
    wr(32'h00, 32'h3);
    run_job(4, 0, 1'b0, 32'h0, 32'h0);
    rd_chk("dto_status", 32'h04, 32'h2);
    rd_chk("dto_cycles", 32'h08, 32'd4);
    check("dto_aborts", 32'(abort_cnt - a0), 0);

    // Done on the CLEAR edge
    wr(32'h04, 32'h6);
    wr(32'h0C, 32'h0);
    a0 = abort_cnt;
    wr(32'h00, 32'h3);
    run_job(2, 3, 1'b1, 32'h00, 32'h6);
    rd_chk("dcl_status", 32'h04, 32'h2);
    rd_chk("dcl_cycles", 32'h08, 32'd2);
    check("dcl_aborts", 32'(abort_cnt - a0), 0);

    // DONE set on the same edge as its write-1-to-clear
    wr(32'h00, 32'h3);
    run_job(3, 4, 1'b1, 32'h04, 32'h2);
    rd_chk("setw1c_status", 32'h04, 32'h2);
    rd_chk("setw1c_cycles", 32'h08, 32'd3);
    wr(32'h04, 32'h2);
    rd_chk("w1c_status", 32'h04, 32'h0);

    // CTRL write without strobe 0 has no effect
    access(1'b1, 32'h00, 32'h1, 4'b1110, rd, er);
    rd_chk("nostrb_status", 32'h04, 32'h0);
    rd_chk("nostrb_ctrl", 32'h00, 32'h2);

    // done while idle is ignored
    @(negedge clk); done_i = 1'b1;
    @(negedge clk); done_i = 1'b0;
    rd_chk("idle_done", 32'h04, 32'h0);

    // Byte-strobed limit
    wr(32'h0C, 32'hAABB_CCDD);
    access(1'b1, 32'h0C, 32'h1122_3344, 4'b0101, rd, er);
    rd_chk("limit_strb", 32'h0C, 32'hAA22_CC44);
    wr(32'h0C, 32'h0);

    // Error responses
    access(1'b0, 32'h14, 32'h0, 4'h0, rd, er);
    check("err_rd14", 32'(er), 1);
    check("err_rd14_data", rd, 32'h0);
    access(1'b1, 32'h14, 32'h1, 4'hF, rd, er);
    check("err_wr14", 32'(er), 1);
    access(1'b1, 32'h10, 32'h1, 4'hF, rd, er);
    check("err_wr10", 32'(er), 1);
    access(1'b1, 32'h08, 32'h1, 4'hF, rd, er);
    check("err_wr08", 32'(er), 1);
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    check("id_err", 32'(er), 0);
    check("id_data", rd, 32'h5A52_1A00);
    rd_chk("err_status", 32'h04, 32'h0);
    rd_chk("err_cycles", 32'h08, 32'd3);

    // Randomized jobs against the event-ordering model
    for (int n = 0; n < 8; n++) begin
      d   = int'($urandom_range(0, 20));
      lim = int'($urandom_range(0, 20));
      c   = int'($urandom_range(0, 20));
      ien = int'($urandom_range(0, 1));
      if (c != 0 && c == lim) c = c + 1;
      if (d == 0 && lim == 0 && c == 0) d = 5;
      predict(d, lim, c, ecyc, est, eab);
      wr(32'h04, 32'h6);
      wr(32'h0C, 32'(lim));
      s0 = start_cnt; a0 = abort_cnt;
      wr(32'h00, 32'h1 | 32'(ien << 1));
      run_job(d, c, 1'b1, 32'h00, 32'h4 | 32'(ien << 1));
      rd_chk("rnd_cycles", 32'h08, 32'(ecyc));
      rd_chk("rnd_status", 32'h04, 32'(est));
      check("rnd_aborts", 32'(abort_cnt - a0), 32'(eab));
      check("rnd_starts", 32'(start_cnt - s0), 1);
      check("rnd_irq", 32'(irq), 32'((ien != 0 && est != 0) ? 1 : 0));
    end

    // Reset during a run, in the start-pulse cycle, with irq high
    wr(32'h04, 32'h6);
    wr(32'h0C, 32'h0);
    wr(32'h00, 32'h3);
    run_job(2, 0, 1'b0, 32'h0, 32'h0);
    wr(32'h0C, 32'h1234);
    wr(32'h00, 32'h3);
    check("pre_rst_start", 32'(start_o), 1);
    check("pre_rst_irq", 32'(irq), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_start", 32'(start_o), 0);
    check("mid_rst_abort", 32'(abort_o), 0);
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_ready", 32'(reg_ready), 0);
    check("mid_rst_error", 32'(reg_error), 0);
    check("mid_rst_rdata", reg_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a0 = abort_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_aborts", 32'(abort_cnt - a0), 0);
    rd_chk("post_rst_limit", 32'h0C, 32'd7);
    rd_chk("post_rst_status", 32'h04, 32'h0);
    rd_chk("post_rst_ctrl", 32'h00, 32'h0);
    rd_chk("post_rst_cycles", 32'h08, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
